// File: rtl/fir_pkg.sv
// Shared definitions for the fir_filter_mac slice: FSM states, default coefficients, clog2.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_t;

  localparam int unsigned DEFAULT_TAPS = 19;

  // Symmetric low-pass prototype, peak at the centre tap.
  localparam int DEFAULT_COEF [DEFAULT_TAPS] = '{
    26, 270, 963, 2424, 4869, 8259, 12194, 15948, 18666, 19660,
    18666, 15948, 12194, 8259, 4869, 2424, 963, 270, 26
  };

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int default_coef(input int unsigned i);
    if (i < DEFAULT_TAPS) return DEFAULT_COEF[i];
    return 0;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate datapath: selects one coef/tap pair per step and accumulates.
module fir_mac
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned TAPS   = 19,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned SHIFT  = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     step,
  input  logic [clog2(TAPS)-1:0]   sel,
  input  logic signed [COEF_W-1:0] coefs [TAPS],
  input  logic signed [DATA_W-1:0] taps  [TAPS],
  output logic signed [ACC_W-1:0]  acc_sum
);

  // Half an output LSB, so the final arithmetic shift rounds half-up.
  localparam logic signed [ACC_W-1:0] BIAS = ACC_W'(1) << (SHIFT - 1);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] coef_x;
  logic signed [ACC_W-1:0] tap_x;
  logic signed [ACC_W-1:0] prod;

  always_comb begin
    coef_x  = ACC_W'(coefs[sel]);
    tap_x   = ACC_W'(taps[sel]);
    prod    = coef_x * tap_x;
    acc_sum = acc + prod;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (start) begin
      acc <= BIAS;
    end else if (step) begin
      acc <= acc_sum;
    end
  end

endmodule

// File: rtl/fir_filter_mac.sv
// Time-multiplexed FIR: one tap per cycle, IDLE/MAC/OUT handshake FSM and delay line.
// Optional macro FIR_SATURATE_EN clamps the output instead of wrapping.
module fir_filter_mac
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned TAPS   = 19,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned SHIFT  = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      out,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   coef_we,
  input  logic [clog2(TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]      coef_data
);

  localparam int unsigned   CW    = clog2(TAPS);
  localparam logic [CW-1:0] LAST  = CW'(TAPS - 1);
  localparam logic [CW:0]   NTAPS = (CW + 1)'(TAPS);

  fir_state_t              state;
  logic [CW-1:0]           n;
  logic signed [DATA_W-1:0] taps  [TAPS];
  logic signed [COEF_W-1:0] coefs [TAPS];
  logic signed [ACC_W-1:0] acc_sum;
  logic [DATA_W-1:0]       out_next;
  logic                    accept;
  logic                    mac_step;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_OUT);
  assign accept    = in_valid & in_ready;
  assign mac_step  = (state == ST_MAC);

  fir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .TAPS   (TAPS),
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .start   (accept),
    .step    (mac_step),
    .sel     (n),
    .coefs   (coefs),
    .taps    (taps),
    .acc_sum (acc_sum)
  );

`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OMIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc_sum >>> SHIFT;
    if (shifted > OMAX)      out_next = OMAX[DATA_W-1:0];
    else if (shifted < OMIN) out_next = OMIN[DATA_W-1:0];
    else                     out_next = shifted[DATA_W-1:0];
  end
`else
  always_comb begin
    out_next = DATA_W'(acc_sum >>> SHIFT);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      n     <= '0;
      out   <= '0;
      for (int unsigned i = 0; i < TAPS; i++) begin
        taps[i]  <= '0;
        coefs[i] <= COEF_W'(default_coef(i));
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (coef_we && ({1'b0, coef_addr} < NTAPS)) coefs[coef_addr] <= coef_data;
          if (accept) begin
            taps[0] <= in;
            for (int unsigned i = 1; i < TAPS; i++) taps[i] <= taps[i-1];
            n     <= '0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          // The last tap's product is folded in combinationally as out is captured.
          if (n == LAST) begin
            out   <= out_next;
            state <= ST_OUT;
          end else begin
            n <= n + CW'(1);
          end
        end
        ST_OUT: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter_mac.sv
// Self-checking bench for fir_filter_mac: vector table, directed corner cases, random vs model.
module tb_fir_filter_mac;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic        in_valid, in_ready;
  logic [15:0] dout;
  logic        out_valid, out_ready;
  logic        coef_we;
  logic [4:0]  coef_addr;
  logic [15:0] coef_data;

  logic [15:0] s_in;
  logic        s_in_valid, s_in_ready;
  logic [15:0] s_out;
  logic        s_out_valid;
  logic        s_out_ready;
  logic        s_coef_we;
  logic [4:0]  s_coef_addr;
  logic [15:0] s_coef_data;

  always #5 clk = ~clk;

  fir_filter_mac u_dut (
    .clk(clk), .reset(reset),
    .in(din), .in_valid(in_valid), .in_ready(in_ready),
    .out(dout), .out_valid(out_valid), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
  );

  fir_filter_mac #(.SHIFT(15)) u_sat (
    .clk(clk), .reset(reset),
    .in(s_in), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out(s_out), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .coef_we(s_coef_we), .coef_addr(s_coef_addr), .coef_data(s_coef_data)
  );

  localparam int DEF [19] = '{26, 270, 963, 2424, 4869, 8259, 12194, 15948, 18666, 19660,
                              18666, 15948, 12194, 8259, 4869, 2424, 963, 270, 26};

  int n_cmp = 0;
  int n_bad = 0;
  int coef_m [19];
  int hist [19];
  int unsigned cyc = 0;
  int unsigned last_acc = 0;
  bit b2b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 19; i++) begin
      coef_m[i] = DEF[i];
      hist[i]   = 0;
    end
  endtask

  // Direct convolution with round-half-up, then the configured narrowing.
  function automatic longint model_out();
    longint acc;
    logic signed [15:0] w;
    acc = longint'(1) <<< 19;
    for (int k = 0; k < 19; k++) acc += longint'(coef_m[k]) * longint'(hist[k]);
    acc = acc >>> 20;
`ifdef FIR_SATURATE_EN
    w = 16'sd0;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    return acc + longint'(w);
`else
    w = acc[15:0];
    return longint'(w);
`endif
  endfunction

  // Entered and left at a negedge with the DUT expected to be idle.
  task automatic run_sample(input logic signed [15:0] s,
                            input bit we_i, input logic [4:0] a_i, input logic signed [15:0] d_i,
                            input bit we_m, input logic [4:0] a_m, input logic signed [15:0] d_m,
                            input int unsigned hold, output logic signed [15:0] got);
    int unsigned guard;
    int unsigned acc_cyc;
    bit early;
    bit moved;
    logic [15:0] held;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", in_ready, 1);
    din = s; in_valid = 1'b1; out_ready = 1'b0;
    coef_we = we_i; coef_addr = a_i; coef_data = d_i;
    @(posedge clk);
    if (we_i && a_i < 19) coef_m[a_i] = d_i;
    for (int i = 18; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
    @(negedge clk);
    acc_cyc = cyc;
    if (b2b) check("throughput", longint'(acc_cyc - last_acc), 21);
    last_acc = acc_cyc;
    in_valid = 1'b0;
    coef_we = we_m; coef_addr = a_m; coef_data = d_m;
    check("busy_in_ready", in_ready, 0);
    early = 0;
    for (int j = 1; j < 19; j++) begin
      @(negedge clk);
      coef_we = 1'b0;
      if (out_valid) early = 1;
    end
    check("latency_early", early, 0);
    @(negedge clk);
    check("latency_valid", out_valid, 1);
    got = dout;
    check("out_vs_model", $signed(dout), model_out());
    moved = 0;
    held = dout;
    for (int h = 0; h < int'(hold); h++) begin
      @(negedge clk);
      if (!out_valid || dout != held || in_ready) moved = 1;
    end
    if (hold > 0) check("backpressure_hold", moved, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_idle", {out_valid, in_ready}, 2'b01);
    b2b = (hold == 0);
  endtask

  typedef struct {
    logic signed [15:0] s;
    logic signed [15:0] exp;
    bit                 chk;
    int unsigned        hold;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [57];
    int   imp_exp [10];
    logic signed [15:0] got;
    logic [15:0] s_got;
    bit early;
    bit timed_out;
    int unsigned guard;

    imp_exp = '{0, 4, 15, 38, 76, 129, 191, 249, 292, 307};
    for (int i = 0; i < 19; i++)
      tbl[i] = '{s: (i == 0) ? 16'sd16384 : 16'sd0, exp: 16'(imp_exp[(i < 10) ? i : 18 - i]),
                 chk: 1'b1, hold: (i == 9) ? 10 : 0};
    for (int i = 19; i < 38; i++) tbl[i] = '{s: 16'sd32767,  exp: 16'sd4590,  chk: (i == 37), hold: 0};
    for (int i = 38; i < 57; i++) tbl[i] = '{s: -16'sd32768, exp: -16'sd4591, chk: (i == 56), hold: 0};

    reset = 1'b1; din = '0; in_valid = 1'b0; out_ready = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    s_in = '0; s_in_valid = 1'b0; s_out_ready = 1'b1;
    s_coef_we = 1'b0; s_coef_addr = '0; s_coef_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out", dout, 0);

    for (int i = 0; i < 57; i++) begin
      run_sample(tbl[i].s, 0, '0, '0, 0, '0, '0, tbl[i].hold, got);
      if (tbl[i].chk) check((i < 19) ? "impulse" : "dc", got, tbl[i].exp);
    end

    // Coefficient write during MAC must be dropped; invalid address ignored.
    for (int i = 0; i < 18; i++)
      run_sample(16'sd0, (i == 3), 5'd25, 16'sd5000, (i == 0), 5'd0, -16'sd1000, 0, got);
    run_sample(16'sd16384, 0, '0, '0, 0, '0, '0, 0, got);
    check("mac_write_dropped", got, 0);
    for (int i = 0; i < 18; i++) run_sample(16'sd0, 0, '0, '0, 0, '0, '0, 0, got);
    run_sample(16'sd1024, 1, 5'd0, -16'sd1000, 0, '0, '0, 0, got);
    check("idle_write_same_cycle", got, -1);

    // Reset in the middle of a MAC pass.
    while (!in_ready) @(negedge clk);
    din = 16'sd1234; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    b2b = 0;
    early = 0;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      if (out_valid) early = 1;
    end
    check("reset_mid_mac_no_valid", early, 0);
    check("reset_mid_mac_out", dout, 0);
    check("reset_mid_mac_ready", in_ready, 1);
    for (int i = 0; i < 19; i++) begin
      run_sample(tbl[i].s, 0, '0, '0, 0, '0, '0, 0, got);
      check("impulse_after_reset", got, tbl[i].exp);
    end

    for (int r = 0; r < 40; r++) begin
      int d1;
      int d2;
      d1 = int'($urandom_range(0, 40000)) - 20000;
      d2 = int'($urandom_range(0, 40000)) - 20000;
      run_sample(16'($urandom), ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), 16'(d1),
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), 16'(d2),
                 $urandom_range(0, 3), got);
    end

    // Output narrowing on the SHIFT=15 instance.
    for (int i = 0; i < 19; i++) begin
      s_coef_we = 1'b1; s_coef_addr = 5'(i); s_coef_data = 16'h7FFF;
      @(negedge clk);
    end
    s_coef_we = 1'b0;
    timed_out = 0;
    s_got = '0;
    for (int i = 0; i < 19; i++) begin
      guard = 0;
      while (!s_in_ready && guard < 60) begin @(negedge clk); guard++; end
      s_in = 16'sd32767; s_in_valid = 1'b1;
      @(negedge clk);
      s_in_valid = 1'b0;
      guard = 0;
      while (!s_out_valid && guard < 60) begin @(negedge clk); guard++; end
      if (!s_out_valid) timed_out = 1;
      s_got = s_out;
    end
    check("sat_timeout", timed_out, 0);
`ifdef FIR_SATURATE_EN
    check("saturate", $signed(s_got), 32767);
`else
    check("wrap", $signed(s_got), 32730);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
